spi_dbg_burst_ctrl: RTL and testbench



---
 rtl/spi_dbg_pkg.sv | 26 ++
 rtl/byte_fifo.sv | 53 +++++
 rtl/spi_dbg_burst_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_spi_dbg_burst_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dbg_pkg.sv
// Shared command/reply codes and FSM encoding for the SPI debug burst engine.
package spi_dbg_pkg;

    localparam logic [7:0] CMD_NOP    = 8'h00;
    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] CMD_LED    = 8'h02;
    localparam logic [7:0] CMD_BURST  = 8'h03;
    localparam logic [7:0] CMD_ADDR_Q = 8'h10;
    localparam logic [7:0] CMD_ID     = 8'hCC;
    localparam logic [7:0] CMD_ECHO   = 8'hCD;

    localparam logic [7:0] RPL_READY  = 8'hFF;
    localparam logic [7:0] RPL_WAIT   = 8'hFE;
    localparam logic [7:0] RPL_LED    = 8'hAB;

    localparam int CNT_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ECHO,
        ST_ADDR,
        ST_LEN,
        ST_BURST
    } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO with flush; dout is the head entry whenever !empty.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push)
            mem[wr_ptr] <= din;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/spi_dbg_burst_ctrl.sv
// SPI debug command engine: decodes host bytes, runs burst flash reads into a
// prefetch FIFO and hands bytes back behind a 0xFF ready marker.
module spi_dbg_burst_ctrl
    import spi_dbg_pkg::*;
#(
    parameter int         ADDR_BYTES = 3,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] DBG_ID     = 8'hCC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    recv_ready,
    input  logic [7:0]              recv_data,
    output logic [7:0]              send_data,
    input  logic                    abort,
    input  logic                    flash_setup_done,
    output logic [8*ADDR_BYTES-1:0] flash_addr,
    output logic                    flash_do_read,
    input  logic                    flash_data_ready,
    input  logic [7:0]              flash_data,
    output logic                    led,
    output logic                    busy
);
    localparam int AW = 8*ADDR_BYTES;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t           state_q, state_nx;
    logic [AW-1:0]    start_addr;
    logic [AW+7:0]    addr_shift;
    logic [AW-1:0]    addr_sel;
    logic [7:0]       addr_left;
    logic             is_burst;
    logic [CNT_W-1:0] total, fetched, popped;
    logic             armed;
    logic             discard;
    logic [7:0]       reply;
    logic             pop_en, push_en, fetch_go;

    logic [7:0]       fifo_dout;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_en),
        .din   (flash_data),
        .pop   (pop_en),
        .flush (abort),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        state_q <= ST_IDLE;
        else            state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        if (abort)
            state_nx = ST_IDLE;
        else if (recv_ready) begin
            case (state_q)
                ST_IDLE: begin
                    if (recv_data == CMD_READ || recv_data == CMD_BURST) state_nx = ST_ADDR;
                    else if (recv_data == CMD_ECHO)                       state_nx = ST_ECHO;
                end
                ST_ECHO:  state_nx = ST_IDLE;
                ST_ADDR:  if (addr_left == 8'd1) state_nx = is_burst ? ST_LEN : ST_BURST;
                ST_LEN:   state_nx = ST_BURST;
                ST_BURST: if (pop_en && (popped + 9'd1 == total)) state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    assign addr_shift = {start_addr, recv_data};
    assign addr_sel   = start_addr >> {recv_data[3:0], 3'b000};

    always_comb begin
        reply  = 8'h00;
        pop_en = 1'b0;
        busy   = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                case (recv_data)
                    CMD_READ, CMD_BURST: reply = 8'(ADDR_BYTES);
                    CMD_LED:             reply = RPL_LED;
                    CMD_ID:              reply = DBG_ID;
                    CMD_ECHO:            reply = CMD_ECHO;
                    default:
                        if (recv_data[7:4] == CMD_ADDR_Q[7:4] &&
                            {4'd0, recv_data[3:0]} < 8'(ADDR_BYTES))
                            reply = addr_sel[7:0];
                endcase
            end
            ST_ECHO:  reply = recv_data;
            ST_ADDR:  reply = addr_left - 8'd1;
            ST_BURST: begin
                if (fifo_empty)  reply = RPL_WAIT;
                else if (!armed) reply = RPL_READY;
                else begin
                    reply  = fifo_dout;
                    pop_en = recv_ready && !abort;
                end
            end
            default:  reply = 8'h00;
        endcase
    end

    // One read outstanding at a time; the free-slot test with do_read low
    // already accounts for the read about to be issued.
    assign fetch_go = (state_q == ST_BURST) && flash_setup_done &&
                      (fetched < total) && (fifo_count < CW'(FIFO_DEPTH));
    assign push_en  = flash_do_read && flash_data_ready && !discard && !abort &&
                      (state_q == ST_BURST) && !fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            send_data     <= 8'h00;
            flash_addr    <= '0;
            flash_do_read <= 1'b0;
            led           <= 1'b0;
            start_addr    <= '0;
            addr_left     <= 8'd0;
            is_burst      <= 1'b0;
            total         <= '0;
            fetched       <= '0;
            popped        <= '0;
            armed         <= 1'b0;
            discard       <= 1'b0;
        end else if (abort) begin
            send_data <= 8'h00;
            armed     <= 1'b0;
            total     <= '0;
            fetched   <= '0;
            popped    <= '0;
            addr_left <= 8'd0;
            // A read already on the flash port must finish; its byte is dropped.
            if (flash_data_ready) begin
                flash_do_read <= 1'b0;
                discard       <= 1'b0;
            end else
                discard <= flash_do_read;
        end else begin
            if (recv_ready) begin
                send_data <= reply;
                case (state_q)
                    ST_IDLE: begin
                        if (recv_data == CMD_READ || recv_data == CMD_BURST) begin
                            addr_left <= 8'(ADDR_BYTES);
                            is_burst  <= (recv_data == CMD_BURST);
                            total     <= 9'd1;
                            fetched   <= '0;
                            popped    <= '0;
                            armed     <= 1'b0;
                        end else if (recv_data == CMD_LED)
                            led <= ~led;
                    end
                    ST_ADDR: begin
                        start_addr <= addr_shift[AW-1:0];
                        addr_left  <= addr_left - 8'd1;
                    end
                    ST_LEN:   total <= {1'b0, recv_data} + 9'd1;
                    ST_BURST: begin
                        if (pop_en) begin
                            armed  <= 1'b0;
                            popped <= popped + 9'd1;
                        end else if (!fifo_empty)
                            armed <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (flash_do_read) begin
                if (flash_data_ready) begin
                    flash_do_read <= 1'b0;
                    discard       <= 1'b0;
                    if (!discard) fetched <= fetched + 9'd1;
                end
            end else if (fetch_go) begin
                flash_do_read <= 1'b1;
                flash_addr    <= start_addr + AW'(fetched);
            end
        end
    end

endmodule

// File: tb/tb_spi_dbg_burst_ctrl.sv
// Directed + randomized bench: host/flash models and an expected-byte model
// derived from address arithmetic.
module tb_spi_dbg_burst_ctrl;
    localparam int         AB    = 3;
    localparam int         DEPTH = 8;
    localparam logic [7:0] ID    = 8'hCC;

    logic        clk = 1'b0;
    logic        rst, recv_ready, abort, flash_setup_done;
    logic [7:0]  recv_data, send_data, flash_data;
    logic [23:0] flash_addr;
    logic        flash_do_read, flash_data_ready, led, busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spi_dbg_burst_ctrl #(.ADDR_BYTES(AB), .FIFO_DEPTH(DEPTH), .DBG_ID(ID)) dut (
        .clk              (clk),
        .rst              (rst),
        .recv_ready       (recv_ready),
        .recv_data        (recv_data),
        .send_data        (send_data),
        .abort            (abort),
        .flash_setup_done (flash_setup_done),
        .flash_addr       (flash_addr),
        .flash_do_read    (flash_do_read),
        .flash_data_ready (flash_data_ready),
        .flash_data       (flash_data),
        .led              (led),
        .busy             (busy)
    );

    logic [7:0]  key;
    logic [23:0] req_q[$];
    int          done_cnt;
    int          lat_max;
    bit          flash_hold, resp_holding;

    function automatic logic [7:0] flash_byte(logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ key;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flash model: one response per request, random latency, optional hold.
    initial begin
        flash_data_ready = 1'b0;
        flash_data       = 8'h00;
        resp_holding     = 1'b0;
        forever begin
            @(negedge clk);
            if (flash_do_read === 1'b1) begin
                logic [23:0] a;
                a = flash_addr;
                req_q.push_back(a);
                resp_holding = 1'b1;
                while (flash_hold) @(negedge clk);
                resp_holding = 1'b0;
                repeat ($urandom_range(lat_max, 0)) @(negedge clk);
                flash_data       = flash_byte(a);
                flash_data_ready = 1'b1;
                done_cnt++;
                @(negedge clk);
                flash_data_ready = 1'b0;
                chk("do_read_drop", {31'd0, flash_do_read}, 0);
            end
        end
    end

    task automatic host(input logic [7:0] b, output logic [7:0] r);
        @(negedge clk);
        recv_data  = b;
        recv_ready = 1'b1;
        @(negedge clk);
        recv_ready = 1'b0;
        r = send_data;
    endtask

    task automatic hostchk(input string tag, input logic [7:0] b, input logic [7:0] exp);
        logic [7:0] r;
        host(b, r);
        chk(tag, {24'd0, r}, {24'd0, exp});
    endtask

    task automatic run_burst(input logic [7:0] cmd, input logic [23:0] sa,
                             input int len, input int gap_max);
        logic [7:0]  r;
        logic [23:0] ea;
        int          k, iter;
        bit          armed;
        req_q.delete();
        done_cnt = 0;
        hostchk("cmd_reply", cmd, 8'(AB));
        hostchk("addr_hi",  sa[23:16], 8'd2);
        hostchk("addr_mid", sa[15:8],  8'd1);
        hostchk("addr_lo",  sa[7:0],   8'd0);
        if (cmd == 8'h03) hostchk("len_reply", 8'(len - 1), 8'd0);
        k = 0; iter = 0; armed = 1'b0;
        while (k < len && iter < 4000) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            host(8'h00, r);
            iter++;
            if (armed) begin
                ea = sa + 24'(k);
                chk("burst_data", {24'd0, r}, {24'd0, flash_byte(ea)});
                k++;
                armed = 1'b0;
            end else if (r != 8'hFF)
                chk("burst_wait", {24'd0, r}, 32'hFE);
            else
                armed = 1'b1;
            chk("fifo_bound", {31'd0, (done_cnt - k <= DEPTH)}, 1);
        end
        chk("burst_done", k, len);
        chk("busy_end", {31'd0, busy}, 0);
        chk("req_count", req_q.size(), len);
        foreach (req_q[i]) begin
            ea = sa + 24'(i);
            chk("req_addr", {8'd0, req_q[i]}, {8'd0, ea});
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; recv_ready = 1'b0; recv_data = 8'h00; abort = 1'b0;
        flash_setup_done = 1'b1; flash_hold = 1'b0; lat_max = 2;
        key = 8'($urandom);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_send",   {24'd0, send_data}, 0);
        chk("rst_addr",   {8'd0, flash_addr}, 0);
        chk("rst_read",   {31'd0, flash_do_read}, 0);
        chk("rst_led",    {31'd0, led}, 0);
        chk("rst_busy",   {31'd0, busy}, 0);

        hostchk("id", 8'hCC, ID);
        hostchk("led_cmd", 8'h02, 8'hAB);
        chk("led_on", {31'd0, led}, 1);
        hostchk("addrq_empty", 8'h10, 8'h00);
        hostchk("echo_cmd", 8'hCD, 8'hCD);
        chk("echo_busy", {31'd0, busy}, 1);
        hostchk("echo_data", 8'h5A, 8'h5A);
        chk("echo_idle", {31'd0, busy}, 0);
        hostchk("nop", 8'h00, 8'h00);
        hostchk("unknown", 8'h55, 8'h00);

        lat_max = 3;
        run_burst(8'h01, 24'h001234, 1, 0);
        hostchk("addrq0", 8'h10, 8'h34);
        hostchk("addrq1", 8'h11, 8'h12);
        hostchk("addrq2", 8'h12, 8'h00);
        hostchk("addrq3", 8'h13, 8'h00);

        run_burst(8'h03, 24'hFFFFFE, 4, 1);
        lat_max = 1;
        run_burst(8'h03, 24'h0A0010, 20, 25);
        lat_max = 2;
        for (int t = 0; t < 4; t++)
            run_burst(8'h03, 24'($urandom), int'($urandom_range(40, 1)), int'($urandom_range(6, 0)));
        lat_max = 0;
        run_burst(8'h03, 24'($urandom), 256, 0);

        // Command accepted with flash not configured; nothing is fetched.
        flash_setup_done = 1'b0;
        req_q.delete();
        hostchk("ns_cmd", 8'h01, 8'd3);
        hostchk("ns_a2", 8'h00, 8'd2);
        hostchk("ns_a1", 8'h00, 8'd1);
        hostchk("ns_a0", 8'h00, 8'd0);
        repeat (20) @(negedge clk);
        chk("ns_no_read", {31'd0, flash_do_read}, 0);
        chk("ns_no_req", req_q.size(), 0);
        hostchk("ns_wait", 8'h00, 8'hFE);
        chk("ns_busy", {31'd0, busy}, 1);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("ns_abort_busy", {31'd0, busy}, 0);
        chk("ns_abort_send", {24'd0, send_data}, 0);
        flash_setup_done = 1'b1;
        repeat (3) @(negedge clk);
        chk("ns_idle_read", {31'd0, flash_do_read}, 0);

        // Abort (with a coincident host byte) while a read is in flight.
        lat_max = 1;
        hostchk("ab_cmd", 8'h03, 8'd3);
        hostchk("ab_a2", 8'h40, 8'd2);
        hostchk("ab_a1", 8'h00, 8'd1);
        hostchk("ab_a0", 8'h00, 8'd0);
        hostchk("ab_len", 8'h0F, 8'd0);
        repeat (6) @(negedge clk);
        flash_hold = 1'b1;
        w = 0;
        while (!resp_holding && w < 100) begin @(negedge clk); w++; end
        chk("ab_inflight", {31'd0, resp_holding}, 1);
        chk("ab_read_hi", {31'd0, flash_do_read}, 1);
        abort = 1'b1; recv_ready = 1'b1; recv_data = 8'hCC;
        @(negedge clk);
        abort = 1'b0; recv_ready = 1'b0;
        chk("ab_busy", {31'd0, busy}, 0);
        chk("ab_send", {24'd0, send_data}, 0);
        flash_hold = 1'b0;
        w = 0;
        while (flash_do_read && w < 20) begin @(negedge clk); w++; end
        chk("ab_read_drop", {31'd0, flash_do_read}, 0);
        repeat (2) @(negedge clk);
        hostchk("ab_id", 8'hCC, ID);
        run_burst(8'h01, 24'h000777, 1, 0);

        // Asynchronous reset mid-read.
        flash_hold = 1'b1;
        hostchk("rs_cmd", 8'h01, 8'd3);
        hostchk("rs_a2", 8'h00, 8'd2);
        hostchk("rs_a1", 8'h00, 8'd1);
        hostchk("rs_a0", 8'h05, 8'd0);
        w = 0;
        while (!resp_holding && w < 100) begin @(negedge clk); w++; end
        chk("rs_read_hi", {31'd0, flash_do_read}, 1);
        #2 rst = 1'b1;
        #1;
        chk("rs_read", {31'd0, flash_do_read}, 0);
        chk("rs_busy", {31'd0, busy}, 0);
        chk("rs_led",  {31'd0, led}, 0);
        chk("rs_addr", {8'd0, flash_addr}, 0);
        @(negedge clk);
        rst = 1'b0;
        flash_hold = 1'b0;
        repeat (8) @(negedge clk);
        chk("rs_idle_read", {31'd0, flash_do_read}, 0);
        chk("rs_idle_busy", {31'd0, busy}, 0);
        hostchk("rs_id", 8'hCC, ID);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
